// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and defaults for the round-robin bus arbiter.
//                Provides the arbiter state enum, default parameter values
//                and a helper for the owner-index width.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int ARB_NUM_REQ  = 4;
    localparam int ARB_MAX_HOLD = 16;

    // Width of a binary requester index; never narrower than one bit.
    function automatic int arb_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_bus_arbiter_if
//  Description : Request/grant bundle between the requesters and the
//                round-robin arbiter.
//  Signals     : req       - level request, one bit per requester
//                gnt       - registered one-hot grant (or zero)
//                gnt_valid - OR of gnt
//                gnt_id    - binary index of the owner, 0 when no grant
//                timeout   - one-cycle pulse on a hold-limit revocation
//  Modports    : master (requester side), slave (arbiter side)
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_bus_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ
) ();

    localparam int IDW = arb_id_width(NUM_REQ);

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_valid;
    logic [IDW-1:0]     gnt_id;
    logic               timeout;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  timeout
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output timeout
    );

endinterface
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating priority encoder. Finds the first set
//                request bit searching upward from last+1, wrapping modulo
//                NUM_REQ.
//  Ports       : req_i         - request vector
//                last_i        - index of the most recent owner
//                found_o       - at least one request is set
//                pick_id_o     - binary index of the chosen requester
//                pick_onehot_o - one-hot form of pick_id_o (zero if !found_o)
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int IDW     = arb_id_width(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [IDW-1:0]     last_i,
    output logic                    found_o,
    output logic [IDW-1:0]          pick_id_o,
    output logic [NUM_REQ-1:0]      pick_onehot_o
);

    int w_dist;
    int w_best;

    // Each requester's distance past last (0 = last+1) is its priority;
    // the set bit with the smallest distance wins.
    always_comb begin
        found_o   = 1'b0;
        pick_id_o = '0;
        w_best    = NUM_REQ;
        w_dist    = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = (j + NUM_REQ - 1 - int'(last_i)) % NUM_REQ;
            if (req_i[j] && (w_dist < w_best)) begin
                w_best    = w_dist;
                found_o   = 1'b1;
                pick_id_o = IDW'(j);
            end
        end
    end

    always_comb begin
        pick_onehot_o = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            pick_onehot_o[j] = found_o && (pick_id_o == IDW'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_bus_arbiter
//  Description : Round-robin arbiter sharing one resource among NUM_REQ
//                level requesters. The grant is registered and one-hot; it is
//                kept until the owner drops its request and the resource is
//                always idle for one cycle between owners.
//  Ports       : clk  - system clock, rising edge
//                nrst - synchronous active-low reset
//                bus  - rr_bus_arbiter_if.slave (req in; gnt, gnt_valid,
//                       gnt_id, timeout out)
//  Config      : ARB_TIMEOUT_EN - when defined, a grant is revoked after
//                MAX_HOLD consecutive cycles and timeout pulses for one cycle.
//                Undefined: no hold counter, timeout tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = ARB_NUM_REQ,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  wire logic       clk,
    input  wire logic       nrst,
    rr_bus_arbiter_if.slave bus
);

    localparam int IDW = arb_id_width(NUM_REQ);

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_GRANT = GRANT;

    generate
        if ((NUM_REQ < 2) || (NUM_REQ > 8) || (MAX_HOLD < 2)) begin : g_bad_param
            $error("rr_bus_arbiter: NUM_REQ must be 2..8 and MAX_HOLD >= 2");
        end
    endgenerate

    logic [0:0]         state_q,  state_d;
    logic [IDW-1:0]     last_q,   last_d;
    logic [NUM_REQ-1:0] gnt_q,    gnt_d;
    logic [IDW-1:0]     gnt_id_q, gnt_id_d;

    logic               w_found;
    logic [IDW-1:0]     w_pick_id;
    logic [NUM_REQ-1:0] w_pick_onehot;
    logic               w_owner_req;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req_i         (bus.req),
        .last_i        (last_q),
        .found_o       (w_found),
        .pick_id_o     (w_pick_id),
        .pick_onehot_o (w_pick_onehot)
    );

    // Owner still requesting; gnt_q is one-hot so a masked OR avoids an
    // index that could exceed NUM_REQ for non-power-of-two sizes.
    assign w_owner_req = |(bus.req & gnt_q);

`ifdef ARB_TIMEOUT_EN
    // Counts completed grant cycles; it stops at MAX_HOLD-1, so the width
    // below always leaves headroom and the counter never wraps.
    localparam int             HW         = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]  HOLD_LIMIT = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q, timeout_d;
`endif

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    gnt_d    = w_pick_onehot;
                    gnt_id_d = w_pick_id;
                    last_d   = w_pick_id;
                    state_d  = S_GRANT;
`ifdef ARB_TIMEOUT_EN
                    hold_d   = '0;
`endif
                end
            end
            S_GRANT: begin
                // Other requesters are ignored here; leaving through IDLE
                // gives the break-before-make gap between owners.
                if (!w_owner_req) begin
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    state_d  = S_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q == HOLD_LIMIT) begin
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
`endif
            end
            default: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            last_q   <= IDW'(NUM_REQ - 1);
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!nrst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = |gnt_q;

endmodule
`default_nettype wire
